// File: rtl/cv32e40p_ft_pkg.sv
// Shared definitions for the fault-tolerant (TMR) wrappers: vote modes and
// default replica-health tuning constants.
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        VM_TMR     = 2'd0,
        VM_DMR     = 2'd1,
        VM_SIMPLEX = 2'd2,
        VM_FAIL    = 2'd3
    } vote_mode_e;

    localparam int unsigned FT_INCREMENT = 4;
    localparam int unsigned FT_DECREMENT = 1;
    localparam int unsigned FT_THRESHOLD = 16;
    localparam int unsigned FT_COUNT_BIT = 6;

    // The number of broken replicas selects how much redundancy is left.
    function automatic vote_mode_e mode_from_broken(input logic [2:0] broken);
        vote_mode_e mode;
        case (broken)
            3'b000:                      mode = VM_TMR;
            3'b001, 3'b010, 3'b100:      mode = VM_DMR;
            3'b011, 3'b101, 3'b110:      mode = VM_SIMPLEX;
            default:                     mode = VM_FAIL;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/cv32e40p_health_counter.sv
// Per-replica health tracker: saturating error counter with a sticky broken
// flag that can be forced (set) or repaired (clear).
module cv32e40p_health_counter
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned INCREMENT = FT_INCREMENT,
    parameter int unsigned DECREMENT = FT_DECREMENT,
    parameter int unsigned THRESHOLD = FT_THRESHOLD,
    parameter int unsigned COUNT_BIT = FT_COUNT_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_blk_err,
    input  logic                 i_set,
    input  logic                 i_clr,
    output logic                 o_broken,
    output logic [COUNT_BIT-1:0] o_cnt
);

    localparam logic [COUNT_BIT-1:0] CNT_MAX = '1;
    localparam logic [COUNT_BIT-1:0] CNT_INC = COUNT_BIT'(INCREMENT);
    localparam logic [COUNT_BIT-1:0] CNT_DEC = COUNT_BIT'(DECREMENT);
    localparam logic [COUNT_BIT-1:0] CNT_THR = COUNT_BIT'(THRESHOLD);

    logic                 r_broken;
    logic [COUNT_BIT-1:0] r_cnt;
    logic [COUNT_BIT:0]   w_sum;
    logic [COUNT_BIT-1:0] w_up;
    logic [COUNT_BIT-1:0] w_down;
    logic [COUNT_BIT-1:0] w_next;

    // The extra carry bit flags overflow, since INCREMENT fits in COUNT_BIT.
    assign w_sum  = {1'b0, r_cnt} + {1'b0, CNT_INC};
    assign w_up   = w_sum[COUNT_BIT] ? CNT_MAX : w_sum[COUNT_BIT-1:0];
    assign w_down = (r_cnt >= CNT_DEC) ? (r_cnt - CNT_DEC) : '0;
    assign w_next = i_blk_err ? w_up : w_down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_broken <= 1'b0;
            r_cnt    <= '0;
        end else if (i_set) begin
            r_broken <= 1'b1;
        end else if (i_clr) begin
            r_broken <= 1'b0;
            r_cnt    <= '0;
        end else if (!r_broken) begin
            r_cnt    <= w_next;
            r_broken <= (w_next >= CNT_THR);
        end
    end

    assign o_broken = r_broken;
    assign o_cnt    = r_cnt;

endmodule

// File: rtl/cv32e40p_tmr_health_voter.sv
// Parametrised TMR voter with per-replica health tracking, graceful
// TMR->DMR->simplex degradation, repair and a sticky first-error log.
module cv32e40p_tmr_health_voter
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned NGRP      = 4,
    parameter int unsigned GW        = 32,
    parameter int unsigned INCREMENT = FT_INCREMENT,
    parameter int unsigned DECREMENT = FT_DECREMENT,
    parameter int unsigned THRESHOLD = FT_THRESHOLD,
    parameter int unsigned COUNT_BIT = FT_COUNT_BIT,
    parameter bit          REG_OUT   = 1'b0,
    localparam int unsigned LGW      = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [2:0][NGRP-1:0][GW-1:0]       to_vote_i,
    output logic [NGRP-1:0][GW-1:0]            voted_o,
    input  logic [2:0]                         set_broken_i,
    input  logic [2:0]                         clr_broken_i,
    output logic [2:0]                         is_broken_o,
    output logic [NGRP-1:0]                    grp_err_o,
    output logic                               err_detected_o,
    output logic                               err_corrected_o,
    output logic                               err_uncorrectable_o,
    output logic [2:0][COUNT_BIT-1:0]          err_cnt_o,
    output logic                               log_valid_o,
    output logic [LGW-1:0]                     log_grp_o,
    output logic [2:0]                         log_blk_o,
    input  logic                               log_clr_i
);

    logic [2:0]                w_broken;
    vote_mode_e                w_mode;
    logic [NGRP-1:0][GW-1:0]   w_maj;
    logic [NGRP-1:0]           w_grp_tmr;
    logic [NGRP-1:0]           w_grp_dmr;
    logic [2:0]                w_blk_tmr;
    logic [1:0]                w_dmr_a;
    logic [1:0]                w_dmr_b;
    logic [1:0]                w_sx;
    logic [NGRP-1:0][GW-1:0]   w_voted;
    logic [NGRP-1:0]           w_grp;
    logic [2:0]                w_blk;
    logic                      w_det;
    logic                      w_corr;
    logic                      w_unc;
    logic [LGW-1:0]            w_low;
    logic                      r_log_valid;
    logic [LGW-1:0]            r_log_grp;
    logic [2:0]                r_log_blk;

    // Mode comes from registered flags so the error path never loops back.
    assign w_mode = mode_from_broken(w_broken);

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            assign w_maj[gi] = (to_vote_i[0][gi] & to_vote_i[1][gi]) |
                               (to_vote_i[0][gi] & to_vote_i[2][gi]) |
                               (to_vote_i[1][gi] & to_vote_i[2][gi]);
            assign w_grp_tmr[gi] = (|(to_vote_i[0][gi] ^ to_vote_i[1][gi])) |
                                   (|(to_vote_i[1][gi] ^ to_vote_i[2][gi]));
            assign w_grp_dmr[gi] = |(to_vote_i[w_dmr_a][gi] ^ to_vote_i[w_dmr_b][gi]);
        end

        for (gi = 0; gi < 3; gi++) begin : g_rep
            assign w_blk_tmr[gi] = |(to_vote_i[gi] ^ w_maj);

            cv32e40p_health_counter #(
                .INCREMENT (INCREMENT),
                .DECREMENT (DECREMENT),
                .THRESHOLD (THRESHOLD),
                .COUNT_BIT (COUNT_BIT)
            ) u_health (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_blk_err (w_blk[gi]),
                .i_set     (set_broken_i[gi]),
                .i_clr     (clr_broken_i[gi]),
                .o_broken  (w_broken[gi]),
                .o_cnt     (err_cnt_o[gi])
            );
        end
    endgenerate

    // Surviving replicas: DMR pair (lower index first) and the simplex one.
    always_comb begin
        w_dmr_a = 2'd0;
        w_dmr_b = 2'd1;
        w_sx    = 2'd0;
        case (w_broken)
            3'b001:  begin w_dmr_a = 2'd1; w_dmr_b = 2'd2; end
            3'b010:  begin w_dmr_a = 2'd0; w_dmr_b = 2'd2; end
            default: begin w_dmr_a = 2'd0; w_dmr_b = 2'd1; end
        endcase
        case (w_broken)
            3'b011:  w_sx = 2'd2;
            3'b101:  w_sx = 2'd1;
            default: w_sx = 2'd0;
        endcase
    end

    always_comb begin
        w_voted = to_vote_i[0];
        w_grp   = '0;
        w_blk   = '0;
        w_det   = 1'b0;
        w_corr  = 1'b0;
        w_unc   = 1'b0;
        case (w_mode)
            VM_TMR: begin
                w_voted = w_maj;
                w_grp   = w_grp_tmr;
                w_blk   = w_blk_tmr;
                w_det   = |w_blk_tmr;
                w_corr  = |w_blk_tmr;
            end
            VM_DMR: begin
                w_voted = to_vote_i[w_dmr_a];
                w_grp   = w_grp_dmr;
                w_det   = |w_grp_dmr;
                w_unc   = |w_grp_dmr;
            end
            VM_SIMPLEX: begin
                w_voted = to_vote_i[w_sx];
            end
            default: begin
                w_unc = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_low = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (w_grp[g]) begin
                w_low = LGW'(g);
            end
        end
    end

    // A clear in the same cycle as a new error re-arms and captures it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_log_valid <= 1'b0;
            r_log_grp   <= '0;
            r_log_blk   <= '0;
        end else if (w_det && (log_clr_i || !r_log_valid)) begin
            r_log_valid <= 1'b1;
            r_log_grp   <= w_low;
            r_log_blk   <= w_blk;
        end else if (log_clr_i) begin
            r_log_valid <= 1'b0;
            r_log_grp   <= '0;
            r_log_blk   <= '0;
        end
    end

    assign log_valid_o = r_log_valid;
    assign log_grp_o   = r_log_grp;
    assign log_blk_o   = r_log_blk;
    assign is_broken_o = w_broken;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [NGRP-1:0][GW-1:0] r_voted;
            logic [NGRP-1:0]         r_grp;
            logic                    r_det;
            logic                    r_corr;
            logic                    r_unc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_voted <= '0;
                    r_grp   <= '0;
                    r_det   <= 1'b0;
                    r_corr  <= 1'b0;
                    r_unc   <= 1'b0;
                end else begin
                    r_voted <= w_voted;
                    r_grp   <= w_grp;
                    r_det   <= w_det;
                    r_corr  <= w_corr;
                    r_unc   <= w_unc;
                end
            end

            assign voted_o             = r_voted;
            assign grp_err_o           = r_grp;
            assign err_detected_o      = r_det;
            assign err_corrected_o     = r_corr;
            assign err_uncorrectable_o = r_unc;
        end else begin : g_comb_out
            assign voted_o             = w_voted;
            assign grp_err_o           = w_grp;
            assign err_detected_o      = w_det;
            assign err_corrected_o     = w_corr;
            assign err_uncorrectable_o = w_unc;
        end
    endgenerate

endmodule

// File: tb/tb_cv32e40p_tmr_health_voter.sv
// Directed bench for the TMR health voter: a combinational-output instance
// drives most checks, a registered-output instance covers latency and reset.
module tb_cv32e40p_tmr_health_voter;

    localparam int NGRP = 4;
    localparam int GW   = 32;
    localparam int CB   = 6;

    logic                          clk;
    logic                          rst_n;
    logic [2:0][NGRP-1:0][GW-1:0]  tv;
    logic [2:0]                    set_b;
    logic [2:0]                    clr_b;
    logic                          log_clr;

    logic [NGRP-1:0][GW-1:0]       voted,   voted_r;
    logic [2:0]                    broken,  broken_r;
    logic [NGRP-1:0]               grp,     grp_r;
    logic                          det,     det_r;
    logic                          corr,    corr_r;
    logic                          unc,     unc_r;
    logic [2:0][CB-1:0]            cnt,     cnt_r;
    logic                          lvalid,  lvalid_r;
    logic [1:0]                    lgrp,    lgrp_r;
    logic [2:0]                    lblk,    lblk_r;

    int n_tot;
    int n_bad;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    cv32e40p_tmr_health_voter #(
        .NGRP(NGRP), .GW(GW), .INCREMENT(4), .DECREMENT(1),
        .THRESHOLD(16), .COUNT_BIT(CB), .REG_OUT(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .to_vote_i(tv), .voted_o(voted),
        .set_broken_i(set_b), .clr_broken_i(clr_b), .is_broken_o(broken),
        .grp_err_o(grp), .err_detected_o(det), .err_corrected_o(corr),
        .err_uncorrectable_o(unc), .err_cnt_o(cnt), .log_valid_o(lvalid),
        .log_grp_o(lgrp), .log_blk_o(lblk), .log_clr_i(log_clr)
    );

    cv32e40p_tmr_health_voter #(
        .NGRP(NGRP), .GW(GW), .INCREMENT(4), .DECREMENT(1),
        .THRESHOLD(16), .COUNT_BIT(CB), .REG_OUT(1'b1)
    ) u_dut_r (
        .clk(clk), .rst_n(rst_n), .to_vote_i(tv), .voted_o(voted_r),
        .set_broken_i(set_b), .clr_broken_i(clr_b), .is_broken_o(broken_r),
        .grp_err_o(grp_r), .err_detected_o(det_r), .err_corrected_o(corr_r),
        .err_uncorrectable_o(unc_r), .err_cnt_o(cnt_r), .log_valid_o(lvalid_r),
        .log_grp_o(lgrp_r), .log_blk_o(lblk_r), .log_clr_i(log_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int r = 0; r < 3; r++)
            for (int g = 0; g < NGRP; g++)
                tv[r][g] = v;
    endtask

    logic [127:0] exp_v;

    initial begin
        n_tot   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        set_b   = '0;
        clr_b   = '0;
        log_clr = 1'b0;
        set_all(32'h0);

        // Reset state
        #12;
        chk("rst_broken", broken, 3'b000);
        chk("rst_cnt", cnt, '0);
        chk("rst_log_valid", lvalid, 1'b0);
        chk("rst_voted_r", voted_r, '0);
        rst_n = 1'b1;
        tick();

        // All replicas agree
        set_all(PAT);
        #1;
        chk("clean_voted", voted, {4{PAT}});
        chk("clean_flags", {det, corr, unc, grp}, 7'b0);
        tick();
        chk("clean_cnt", cnt, '0);

        // Single-cycle upset in replica 1, group 2
        tv[1][2] = PAT ^ 32'h1;
        #1;
        chk("tmr_corr", {det, corr, unc}, 3'b110);
        chk("tmr_grp", grp, 4'b0100);
        chk("tmr_voted", voted, {4{PAT}});
        tick();
        set_all(PAT);
        chk("tmr_cnt1", cnt[1], 4);
        chk("log1", {lvalid, lgrp, lblk}, {1'b1, 2'd2, 3'b010});
        for (int k = 0; k < 4; k++) tick();
        chk("decay_cnt1", cnt[1], 0);

        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        chk("log_cleared", lvalid, 1'b0);

        // Replica 2 persistently wrong: breaks on the 4th edge
        tv[2][0] = ~PAT;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("cnt2_step%0d", k), cnt[2], 4 * k);
            chk($sformatf("brk_step%0d", k), broken, (k == 4) ? 3'b100 : 3'b000);
        end
        chk("log2", {lvalid, lgrp, lblk}, {1'b1, 2'd0, 3'b100});
        chk("dmr_quiet", {det, corr, unc, grp}, 7'b0);
        chk("dmr_voted", voted, {4{PAT}});
        tick();
        chk("cnt2_frozen", cnt[2], 16);

        // DMR disagreement with simultaneous log clear
        set_all(PAT);
        tv[0][1] = 32'h1;
        tv[1][1] = 32'h3;
        log_clr  = 1'b1;
        #1;
        exp_v = {4{PAT}};
        exp_v[63:32] = 32'h1;
        chk("dmr_voted_mis", voted, exp_v);
        chk("dmr_flags", {det, corr, unc}, 3'b101);
        chk("dmr_grp", grp, 4'b0010);
        tick();
        log_clr = 1'b0;
        chk("log_dmr", {lvalid, lgrp, lblk}, {1'b1, 2'd1, 3'b000});
        chk("dmr_cnt01", {cnt[1], cnt[0]}, '0);

        // Repair replica 2, then set/clr conflict leaves 0,1 broken
        set_all(PAT);
        clr_b = 3'b100;
        tick();
        clr_b = 3'b000;
        chk("repair2", {broken, cnt[2]}, {3'b000, 6'd0});
        for (int g = 0; g < NGRP; g++) begin
            tv[0][g] = 32'h11111111;
            tv[1][g] = 32'h22222222;
            tv[2][g] = 32'h33333333;
        end
        set_b = 3'b011;
        clr_b = 3'b001;
        tick();
        set_b = 3'b000;
        clr_b = 3'b000;
        chk("set_wins", broken, 3'b011);
        chk("sx_voted", voted, {4{32'h33333333}});
        chk("sx_flags", {det, corr, unc, grp}, 7'b0);
        chk("sx_cnt01", {cnt[1], cnt[0]}, '0);
        clr_b = 3'b011;
        tick();
        clr_b = 3'b000;
        chk("back_tmr", {broken, cnt}, '0);
        set_all(PAT);
        tv[0][3] = 32'h0;
        #1;
        chk("tmr_again", {corr, grp}, 5'b11000);
        tick();
        chk("tmr_again_cnt0", cnt[0], 4);

        // All replicas broken
        set_all(PAT);
        tv[0][0] = 32'h12345678;
        set_b = 3'b111;
        tick();
        set_b = 3'b000;
        exp_v = {4{PAT}};
        exp_v[31:0] = 32'h12345678;
        chk("fail_voted", voted, exp_v);
        chk("fail_flags", {det, corr, unc, grp}, 7'b0010000);
        clr_b = 3'b111;
        tick();
        clr_b = 3'b000;

        // Registered outputs: one-cycle latency, then async reset mid-burst
        set_all(PAT);
        tick();
        tv[1][2] = PAT ^ 32'h1;
        #1;
        chk("reg_latency", {corr_r, corr}, 2'b01);
        tick();
        chk("reg_corr", {det_r, corr_r, unc_r}, 3'b110);
        chk("reg_grp", grp_r, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_voted_r", voted_r, '0);
        chk("rst_mid_flags_r", {det_r, corr_r, unc_r, grp_r}, 7'b0);
        chk("rst_mid_state_r", {broken_r, cnt_r, lvalid_r, lgrp_r, lblk_r}, '0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
